// File: rtl/ifetch_stage_if.sv
// Instruction-memory request/response channel between ifetch_stage (master) and
// the instruction memory (slave). Requests are address-only; responses return in order.
interface ifetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: fetch PC, in-order prefetch queue and wrong-path response drop.
// Optional delivered-instruction counter on fetch_count when IFETCH_PERF_CNT_EN is defined.
module ifetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'hE1A0_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  ifetch_stage_if.master       imem,
  output logic [31:0]          InstrF,
  output logic [31:0]          PCPlus8,
  output logic                 InstrValidF
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = 16;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // NOTE: queue storage has no reset; count_q alone decides which entries are live.
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc8_mem   [DEPTH];

  logic          head_valid;
  logic          pop;
  logic          push;
  logic          rsp_live;
  logic          accept;
  logic          req;
  logic [CNT_W:0] occupancy;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign head_valid = (count_q != '0);
  // A head consumed in a redirect cycle belongs to the flushed path, so it is not a pop.
  assign pop        = ~stall & ~redirect & head_valid;
  assign rsp_live   = imem.imem_rvalid & (drop_q == '0);
  assign push       = rsp_live & ~redirect;

  // Slots reserved by the queue and by in-flight requests; the head leaving this
  // cycle frees its slot early so a 1-cycle memory can sustain one word per cycle.
  assign occupancy  = {1'b0, count_q} + {1'b0, out_q} - {{CNT_W{1'b0}}, pop};
  assign req        = reset & ~redirect & (occupancy < DEPTH_OCC);
  assign accept     = req & imem.imem_ready;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign InstrValidF = head_valid;
  assign InstrF      = head_valid ? instr_mem[rd_ptr_q] : NOP;
  assign PCPlus8     = head_valid ? pc8_mem[rd_ptr_q]   : pc_q + 32'd8;

  // NOTE: every _d takes its _q value first so no path through this block infers a latch.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    out_d     = out_q;
    drop_d    = drop_q;

    if (redirect) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      resp_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      out_d     = '0;
      // Everything still in flight is now wrong-path; a response landing this cycle
      // retires one of those immediately.
      drop_d    = drop_q + DROP_W'(out_q) - DROP_W'(imem.imem_rvalid);
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem.imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - DROP_W'(1);
      end
      out_d = out_q + CNT_W'(accept) - CNT_W'(rsp_live);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses <= so every register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem.imem_rdata;
      pc8_mem[wr_ptr_q]   <= resp_pc_q + 32'd8;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_q == DEPTH_CNT)));

  a_no_unexpected_rsp: assert property (@(posedge clk) disable iff (!reset)
    !(imem.imem_rvalid && (out_q == '0) && (drop_q == '0)));
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: in-order memory model with adjustable latency, a PC model and
// a scoreboard of expected {instr, pc+8} pushed on live responses and popped on delivery.
module tb_ifetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hE1A0_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] InstrF;
  logic [31:0] PCPlus8;
  logic        InstrValidF;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  ifetch_stage_if imem ();

  ifetch_stage #(.DEPTH(2), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .InstrF      (InstrF),
    .PCPlus8     (PCPlus8),
    .InstrValidF (InstrValidF)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  req_t        pending[$];
  exp_t        sb[$];
  req_t        cur;
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_pass = 0;
  int          n_total = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hEB00_0000 ^ a;
  endfunction

  // Memory: responds in order, each accepted request after mem_lat cycles.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      cur = pending.pop_front();
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = word_of(cur.addr);
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Mid-cycle monitor: head vs scoreboard, request address vs PC model, bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      n_total++;
      if (imem.imem_req !== 1'b0) $display("FAIL req_in_reset: got %b want 0", imem.imem_req);
      else n_pass++;
      pending.delete();
      sb.delete();
      exp_pc    = RESET_PC;
      delivered = 0;
    end else begin
      if (InstrValidF === 1'b1) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL head_unexpected: got pc8=%h with no word expected", PCPlus8);
        end else if (InstrF !== sb[0].instr || PCPlus8 !== sb[0].pc8) begin
          $display("FAIL head: got %h/%h want %h/%h", InstrF, PCPlus8, sb[0].instr, sb[0].pc8);
        end else n_pass++;
        if (!stall && !redirect) begin
          if (sb.size() > 0) void'(sb.pop_front());
          delivered++;
        end
      end else begin
        n_total++;
        if (InstrF !== NOP || PCPlus8 !== exp_pc + 32'd8 || InstrValidF !== 1'b0)
          $display("FAIL empty_head: got %h/%h/%b want %h/%h/0", InstrF, PCPlus8, InstrValidF,
                   NOP, exp_pc + 32'd8);
        else n_pass++;
      end
      if (imem.imem_req === 1'b1 && imem.imem_ready === 1'b1) begin
        n_total++;
        if (imem.imem_addr !== exp_pc) $display("FAIL req_addr: got %h want %h", imem.imem_addr, exp_pc);
        else n_pass++;
        pending.push_back('{addr: exp_pc, due: cyc + mem_lat, stale: 1'b0});
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        n_total++;
        if (imem.imem_req !== 1'b0) $display("FAIL req_in_redirect: got %b want 0", imem.imem_req);
        else n_pass++;
        sb.delete();
        foreach (pending[i]) pending[i].stale = 1'b1;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem.imem_rvalid === 1'b1 && !cur.stale) begin
        sb.push_back('{instr: word_of(cur.addr), pc8: cur.addr + 32'd8});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    settle();
    n_total++;
    if (imem.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem.imem_req);
    else n_pass++;
    n_total++;
    if (imem.imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem.imem_addr, RESET_PC);
    else n_pass++;
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL reset_head: got %b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    n_total++;
    if (PCPlus8 !== RESET_PC + 32'd8) $display("FAIL reset_pcplus8: got %h want %h", PCPlus8, RESET_PC + 32'd8);
    else n_pass++;
`ifdef IFETCH_PERF_CNT_EN
    n_total++;
    if (fetch_count !== 32'd0) $display("FAIL reset_fetch_count: got %0d want 0", fetch_count);
    else n_pass++;
`endif
  endtask

  task automatic test_stream();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      settle();
      n_total++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC + 32'(4 * i))
        $display("FAIL stream_req%0d: got %b/%h want 1/%h", i, imem.imem_req, imem.imem_addr,
                 RESET_PC + 32'(4 * i));
      else n_pass++;
      n_total++;
      if (i < 2) begin
        if (InstrValidF !== 1'b0) $display("FAIL stream_valid%0d: got %b want 0", i, InstrValidF);
        else n_pass++;
      end else begin
        if (InstrValidF !== 1'b1 || PCPlus8 !== RESET_PC + 32'(8 + 4 * (i - 2)) ||
            InstrF !== word_of(RESET_PC + 32'(4 * (i - 2))))
          $display("FAIL stream_head%0d: got %b/%h/%h want 1/%h/%h", i, InstrValidF, InstrF, PCPlus8,
                   word_of(RESET_PC + 32'(4 * (i - 2))), RESET_PC + 32'(8 + 4 * (i - 2)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    exp_t h;
    step();
    stall = 1'b1;
    settle();
    h = sb.size() > 0 ? sb[0] : '{instr: NOP, pc8: 32'hFFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        step();
        settle();
      end
      n_total++;
      if (InstrValidF !== 1'b1 || InstrF !== h.instr || PCPlus8 !== h.pc8)
        $display("FAIL stall_hold%0d: got %b/%h/%h want 1/%h/%h", k, InstrValidF, InstrF, PCPlus8,
                 h.instr, h.pc8);
      else n_pass++;
    end
    n_total++;
    if (imem.imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem.imem_req);
    else n_pass++;
    step();
    stall = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_redirect();
    bit got = 1'b0;
    mem_lat = 3;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      settle();
      if (pending.size() >= 2) got = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL redirect_setup: got %0d in flight want 2", pending.size());
    else n_pass++;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    settle();
    n_total++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0000_0100)
      $display("FAIL redirect_req: got %b/%h want 1/00000100", imem.imem_req, imem.imem_addr);
    else n_pass++;
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL redirect_flush: got %b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      settle();
      if (InstrValidF === 1'b1) got = 1'b1;
    end
    n_total++;
    if (!got || PCPlus8 !== 32'h0000_0108 || InstrF !== word_of(32'h0000_0100))
      $display("FAIL redirect_first: got %b/%h/%h want 1/%h/00000108", got, InstrF, PCPlus8,
               word_of(32'h0000_0100));
    else n_pass++;
    mem_lat = 1;
    repeat (6) step();
  endtask

  task automatic test_ready_low();
    logic [31:0] a;
    step();
    imem.imem_ready = 1'b0;
    settle();
    a = exp_pc;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        step();
        settle();
      end
      n_total++;
      if (imem.imem_addr !== a) $display("FAIL ready_low_addr%0d: got %h want %h", k, imem.imem_addr, a);
      else n_pass++;
    end
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL ready_low_drain: got %b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    step();
    imem.imem_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_mid_reset();
    step();
    stall = 1'b1;
    repeat (2) step();
    settle();
    n_total++;
    if (InstrValidF !== 1'b1 || sb.size() != 2)
      $display("FAIL mid_reset_setup: got valid=%b queued=%0d want 1/2", InstrValidF, sb.size());
    else n_pass++;
    step();
    reset = 1'b0;
    stall = 1'b0;
    step();
    reset = 1'b1;
    settle();
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL mid_reset_head: got %b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    n_total++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC)
      $display("FAIL mid_reset_addr: got %b/%h want 1/%h", imem.imem_req, imem.imem_addr, RESET_PC);
    else n_pass++;
`ifdef IFETCH_PERF_CNT_EN
    n_total++;
    if (fetch_count !== 32'd0) $display("FAIL mid_reset_count: got %0d want 0", fetch_count);
    else n_pass++;
`endif
  endtask

  task automatic test_perf();
    bit got = 1'b0;
    for (int k = 0; k < 40 && delivered < 6; k++) step();
    stall = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      settle();
      if (sb.size() == 2 && InstrValidF === 1'b1) got = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL perf_fill: got queued=%0d want 2", sb.size());
    else n_pass++;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    settle();
    n_total++;
    if (InstrValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL stall_redirect_flush: got %b/%h want 0/%h", InstrValidF, InstrF, NOP);
    else n_pass++;
    stall = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      stall = (delivered >= 10);
      if (delivered >= 10) break;
    end
    settle();
    n_total++;
    if (delivered != 10) $display("FAIL perf_deliver: got %0d delivered want 10", delivered);
    else n_pass++;
`ifdef IFETCH_PERF_CNT_EN
    n_total++;
    if (fetch_count !== 32'd10) $display("FAIL fetch_count: got %0d want 10", fetch_count);
    else n_pass++;
`endif
    step();
    stall = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    reset            = 1'b0;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 32'h0;
    imem.imem_ready  = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    cur              = '{addr: 32'h0, due: 0, stale: 1'b1};
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_low();
    test_mid_reset();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the pipelined ARM core, directly upstream of the decode stage. It owns the fetch PC and issues word requests to instruction memory over a request/response handshake. Returned words are buffered in a small in-order prefetch queue, and the stage presents `InstrF`/`PCPlus8` to decode. It honours decode stalls and flushes on taken-branch redirects, discarding any in-flight responses fetched on the wrong path.

## Interface

**Parameters**
- `DEPTH`, 2: prefetch queue entries; power of two, ≥2; also caps outstanding memory requests.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP`, 32'hE1A0_0000: `MOV r0,r0`, driven on `InstrF` when no valid instruction is available.

**Ports**
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; state clears on a rising edge where `reset`=0.
- `stall`  in  1: decode stall; holds the queue head and suppresses pop.
- `redirect`  in  1: taken branch / PC write; flushes the stage.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1: request valid.
- `imem_addr`  out  32: request word address, PC.
- `imem_ready`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: response valid; responses return in order, latency ≥1.
- `imem_rdata`  in  32: response instruction word.
- `InstrF`  out  32: head instruction to decode.
- `PCPlus8`  out  32: head instruction address + 8.
- `InstrValidF`  out  1: head is a real instruction.
- `fetch_count`  out  32: present only with `IFETCH_PERF_CNT_EN`.

## Operation

**State**
- `pc`: 32-bit fetch PC.
- Queue: `DEPTH` entries of {instr, pc+8}, with `count`.
- `outstanding`: accepted requests not yet returned.
- `drop`: responses still to be discarded after a redirect.

**Request and response flow**
- Request rule: `imem_req` = `reset` & ~`redirect` & (`count` + `outstanding` < `DEPTH`).
- Accept occurs when `imem_req` & `imem_ready`. On accept, `pc` += 4 (wraps modulo 2^32) and `outstanding`++.
- Response handling on `imem_rvalid`:
  - If `drop`>0: `drop`-- and the word is discarded.
  - Otherwise: push {`imem_rdata`, addr+8}. The address is tracked by an in-order tag queue or by a separate response-PC register advanced by 4.
- Every response decrements `outstanding`.
- The queue never overflows, because reservation is counted at request time.

**Head and pop**
- Head: if `count`>0, `InstrF`/`PCPlus8` = queue head and `InstrValidF`=1. Otherwise `InstrF`=`NOP`, `PCPlus8`=`pc`+8 and `InstrValidF`=0.
- Pop occurs when ~`stall` & `count`>0.
- Push and pop may occur in the same cycle; `count` is then unchanged.

**Redirect (highest priority)**
- `pc` ← `redirect_pc`&~3.
- The queue is cleared (`count`=0).
- `drop` ← `outstanding` + `drop` − (1 if a response arrives this cycle).
- No request is issued in the redirect cycle.
- A response arriving in the redirect cycle is always discarded.
- A redirect during `stall` still flushes.

**Reset**
- A reset mid-operation clears `pc`, the queue, `outstanding` and `drop`.
- Memory responses to pre-reset requests are not tracked. The memory must be reset together with this stage.

## Timing

- **Outputs during reset:** `imem_req`=0, `imem_addr`=`RESET_PC`, `InstrF`=`NOP`, `InstrValidF`=0, `PCPlus8`=`RESET_PC`+8, `fetch_count`=0.
- **First request:** issued in the first cycle with `reset`=1, addr=`RESET_PC`.
- **Response to decode:** a word with `imem_rvalid` in cycle N appears on `InstrF` in cycle N+1. There is no combinational bypass.
- **Throughput:** one instruction per cycle with 1-cycle memory and `DEPTH`≥2.
- **Redirect:** `redirect` in cycle N gives `imem_req` with `imem_addr`=`redirect_pc` in cycle N+1. The first new instruction is valid no earlier than N+3 with 1-cycle memory.
- **Flush:** in cycle N+1 after a redirect, `InstrValidF`=0 and `InstrF`=`NOP`.
- **Stall:** with `stall` held, `InstrF`/`PCPlus8` are stable. Fetching continues until `count`+`outstanding`=`DEPTH`.

## Configuration

- **`IFETCH_PERF_CNT_EN` defined:**
  - `fetch_count` exists, reset to 0.
  - It increments on each pop, i.e. each instruction delivered to decode.
  - It wraps at 2^32 and does not count discarded or flushed words.
- **`IFETCH_PERF_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

- **Reset release, `imem_ready`=1, 1-cycle memory returning addr-derived words:** requests 0x0, 0x4, 0x8 on consecutive cycles. `InstrF` sequence follows from cycle 2 with `PCPlus8`=0x8, 0xC, 0x10, and `InstrValidF` stays 1.
- **`stall` held 3 cycles after the first valid instruction:** `InstrF`/`PCPlus8` hold at 0x8. `imem_req` drops once 2 entries are queued or outstanding. Release resumes in order with no loss or duplication.
- **`redirect`=1, `redirect_pc`=0x103 with 2 requests outstanding:** next `imem_addr`=0x100. Both old responses are discarded. The first valid `PCPlus8` is 0x108 and `NOP` is shown meanwhile.
- **`imem_ready` low for 4 cycles:** `imem_addr` is held constant. `InstrValidF` goes 0 once the queue drains, and decode sees `NOP`.
- **Reset asserted mid-stream with `count`=2:** the next cycle shows `InstrValidF`=0 and `imem_addr`=`RESET_PC`. With `IFETCH_PERF_CNT_EN`, `fetch_count`=0.
- **`IFETCH_PERF_CNT_EN` build, 10 delivered instructions plus one redirect flushing 2:** `fetch_count`=10.
